gf_power_seq: RTL and testbench

//  Sequential power-map engine: y = x^e in GF(2^M), polynomial basis, runtime exponent.

---
 rtl/gf_power_seq.sv | 135 +++++++++++++
 tb/tb_gf_power_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_power_seq.sv
// gf_power_seq: sequential y = x^e in GF(2^M), polynomial basis, runtime exponent.
// Square-and-multiply, MSB-first, one exponent bit per cycle. A single operation is
// in flight at a time: IDLE accepts, RUN iterates M times, DONE holds the result.
// Optional feature macro: GF_POW_INV_EN adds in_inv_i, which forces e = 2^M-2
// (multiplicative inverse, 0 maps to 0) without changing latency.
module gf_power_seq #(
  parameter int unsigned M    = 6,
  parameter logic [M:0]  POLY = 7'b1000011
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [M-1:0] in_x_i,
  input  logic [M-1:0] in_e_i,
`ifdef GF_POW_INV_EN
  input  logic         in_inv_i,
`endif
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [M-1:0] out_y_o
);

  localparam int unsigned CntW = (M > 1) ? $clog2(M) : 1;
  localparam logic [M-1:0] One = M'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [M-1:0]      xr_q, xr_d;
  logic [M-1:0]      er_q, er_d;
  logic [M-1:0]      acc_q, acc_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [M-1:0]      out_y_q, out_y_d;
  logic              out_valid_q, out_valid_d;

  logic [M-1:0]      sq;
  logic [M-1:0]      mul_op;
  logic [M-1:0]      acc_step;
  logic [M-1:0]      e_sel;

  // Carry-less product reduced by POLY; interleaved reduction keeps the partial
  // result within M+1 bits so no wide product is ever formed.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [M:0] r;
    r = '0;
    for (int i = M - 1; i >= 0; i--) begin
      r = {r[M-1:0], 1'b0};
      if (r[M]) r = r ^ POLY;
      if (b[i]) r = r ^ {1'b0, a};
    end
    return r[M-1:0];
  endfunction

  // Exponent captured at accept; the inverse request substitutes 2^M-2.
  always_comb begin
    e_sel = in_e_i;
`ifdef GF_POW_INV_EN
    if (in_inv_i) e_sel = {{(M-1){1'b1}}, 1'b0};
`endif
  end

  // One square-and-multiply step on the current exponent bit.
  always_comb begin
    sq       = gf_mul(acc_q, acc_q);
    mul_op   = er_q[cnt_q] ? xr_q : One;
    acc_step = gf_mul(sq, mul_op);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    xr_d        = xr_q;
    er_d        = er_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_y_d     = out_y_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          xr_d    = in_x_i;
          er_d    = e_sel;
          acc_d   = One;
          cnt_d   = CntW'(M - 1);
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_step;
        if (cnt_q == '0) begin
          out_y_d     = acc_step;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        // Only the result is retired here; a new operand waits for IDLE.
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      xr_q        <= '0;
      er_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_y_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      xr_q        <= xr_d;
      er_q        <= er_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = out_valid_q;
  assign out_y_o     = out_y_q;

endmodule

// File: tb/tb_gf_power_seq.sv
// Scoreboard bench for gf_power_seq (M=6, x^6+x+1). The driver pushes expected
// results and accept cycles; the monitor pops and compares on each out_valid rise.
module tb_gf_power_seq;

  localparam int unsigned M = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_x = '0;
  logic [5:0] in_e = '0;
`ifdef GF_POW_INV_EN
  logic       in_inv = 1'b0;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_y;

  logic       dir_ready = 1'b1;
  logic       rnd_mode = 1'b0;
  logic       rnd_ready = 1'b1;

  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  logic [5:0] exp_q[$];
  int         lat_q[$];

  gf_power_seq #(.M(M), .POLY(7'b1000011)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_x_i      (in_x),
    .in_e_i      (in_e),
`ifdef GF_POW_INV_EN
    .in_inv_i    (in_inv),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_y_o     (out_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign out_ready = rnd_mode ? rnd_ready : dir_ready;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, expv, $time);
  endtask

  // Reference: full polynomial product then top-down reduction.
  function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
    logic [11:0] p;
    logic [11:0] pm;
    p  = '0;
    pm = 12'b000001000011;
    for (int i = 0; i < 6; i++) if (b[i]) p = p ^ ({6'b0, a} << i);
    for (int k = 11; k >= 6; k--) if (p[k]) p = p ^ (pm << (k - 6));
    return p[5:0];
  endfunction

  // Reference power by repeated multiplication (no square-and-multiply).
  function automatic logic [5:0] ref_pow(input logic [5:0] x, input logic [5:0] e);
    logic [5:0] r;
    r = 6'h01;
    for (int i = 0; i < int'(e); i++) r = ref_mul(r, x);
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accept edge.
  task automatic issue(input logic [5:0] x, input logic [5:0] e, input logic [5:0] expv);
    int guard;
    guard = 0;
    in_x = x;
    in_e = e;
    in_valid = 1'b1;
    while (!in_ready && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    exp_q.push_back(expv);
    lat_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (!(exp_q.size() == 0 && in_ready) && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!(exp_q.size() == 0 && in_ready)) check("drain_timeout", 0, 1);
  endtask

  // Monitor: compares result value and latency on every out_valid rise.
  initial begin
    logic       prev;
    logic [5:0] ev;
    int         lc;
    prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (out_valid && !prev) begin
          if (exp_q.size() == 0) begin
            check("spurious_result", 1, 0);
          end else begin
            ev = exp_q.pop_front();
            lc = lat_q.pop_front();
            check("result", 32'(out_y), 32'(ev));
            check("latency", cyc - lc, 6);
          end
        end
        prev = out_valid;
      end
    end
  end

  initial begin
    logic [5:0] rx;
    logic [5:0] re;
    int         guard;

    // Reset values
    #12;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_y", 32'(out_y), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", 32'(in_ready), 1);
    check("idle_out_valid", 32'(out_valid), 0);

    // Basic and boundary vectors
    issue(6'h02, 6'd34, 6'h24);
    drain();
    issue(6'h02, 6'd0, 6'h01);
    issue(6'h00, 6'd0, 6'h01);
    issue(6'h00, 6'd5, 6'h00);
    issue(6'h02, 6'd63, 6'h01);
    issue(6'h02, 6'd6, 6'h03);
    drain();

    // Backpressure with stray operands offered during RUN/DONE
    dir_ready = 1'b0;
    issue(6'h02, 6'd34, 6'h24);
    in_x = 6'h07;
    in_e = 6'd3;
    in_valid = 1'b1;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk);
      #1;
      check("busy_in_ready", 32'(in_ready), 0);
      guard++;
    end
    check("bp_result_seen", 32'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_out_y", 32'(out_y), 32'h24);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    dir_ready = 1'b1;
    @(posedge clk);
    #1;
    check("retire_out_valid", 32'(out_valid), 0);
    check("retire_in_ready", 32'(in_ready), 1);
    check("retire_out_y", 32'(out_y), 32'h24);
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("no_stray_accept", 32'(in_ready), 1);

    // Reset in the third RUN cycle
    issue(6'h02, 6'd34, 6'h24);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_out_y", 32'(out_y), 0);
    check("abort_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_result", 32'(out_valid), 0);
    issue(6'h02, 6'd6, 6'h03);
    drain();

    // Random operands against the reference model, random out_ready
    rnd_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rx = 6'($urandom);
      re = 6'($urandom);
      issue(rx, re, ref_pow(rx, re));
    end
    drain();
    rnd_mode = 1'b0;

`ifdef GF_POW_INV_EN
    in_inv = 1'b1;
    issue(6'h02, 6'd34, 6'h21);
    issue(6'h00, 6'd34, 6'h00);
    for (int x = 1; x < 64; x++) issue(6'(x), 6'($urandom), ref_pow(6'(x), 6'd62));
    drain();
    in_inv = 1'b0;
`endif

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
